// File: rtl/vga_sync_gen.sv
// VGA sync stage: vertical line counter, vertical-phase FSM and registered sync/video outputs.
// Optional `VGA_FRAME_CNT_EN adds an 8-bit frame counter output (frame_cnt).
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] h_count_i,
  input  logic        v_count_en_i,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [15:0] v_count,
  output logic        line_start,
`ifdef VGA_FRAME_CNT_EN
  output logic        frame_start,
  output logic [7:0]  frame_cnt
`else
  output logic        frame_start
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] LP_H_ACT_END  = 16'(H_ACTIVE);
  localparam logic [15:0] LP_HS_START   = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] LP_HS_END     = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] LP_H_TOTAL    = 16'(H_TOTAL);
  localparam logic [15:0] LP_V_FP_START = 16'(V_ACTIVE);
  localparam logic [15:0] LP_VS_START   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] LP_VB_START   = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] LP_V_LAST     = 16'(V_TOTAL - 1);

  typedef enum logic [1:0] {StVAct, StVFp, StVSync, StVBp} v_state_e;

  v_state_e    r_state, w_state_next;
  logic [15:0] r_v_count, w_v_next;
  logic        r_hsync, r_vsync, r_video_on, r_line_start, r_frame_start;
  logic [9:0]  r_pixel_x, r_pixel_y;
  logic        w_h_act, w_h_sync, w_video_on, w_frame_start;

  // Next line/phase are computed here so the output registers see the new line on the same
  // edge that advances the counter, keeping row and column aligned.
  always_comb begin
    w_v_next      = r_v_count;
    w_state_next  = r_state;
    w_frame_start = v_count_en_i && (r_v_count == LP_V_LAST);
    if (v_count_en_i) begin
      w_v_next = (r_v_count == LP_V_LAST) ? '0 : r_v_count + 16'd1;
      unique case (r_state)
        StVAct:  if (w_v_next == LP_V_FP_START) w_state_next = StVFp;
        StVFp:   if (w_v_next == LP_VS_START)   w_state_next = StVSync;
        StVSync: if (w_v_next == LP_VB_START)   w_state_next = StVBp;
        StVBp:   if (w_v_next == '0)            w_state_next = StVAct;
        default: w_state_next = StVAct;
      endcase
    end
    // Out-of-range h falls outside both windows, so it reads as plain blanking.
    w_h_act    = (h_count_i < LP_H_ACT_END) && (h_count_i < LP_H_TOTAL);
    w_h_sync   = (h_count_i >= LP_HS_START) && (h_count_i < LP_HS_END);
    w_video_on = w_h_act && (w_state_next == StVAct);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= StVAct;
      r_v_count     <= '0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_v_count     <= w_v_next;
      r_hsync       <= w_h_sync ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= (w_state_next == StVSync) ? SYNC_POL : ~SYNC_POL;
      r_video_on    <= w_video_on;
      r_pixel_x     <= w_video_on ? h_count_i[9:0] : '0;
      r_pixel_y     <= w_video_on ? w_v_next[9:0] : '0;
      r_line_start  <= v_count_en_i;
      r_frame_start <= w_frame_start;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (r_frame_start) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign pixel_x     = r_pixel_x;
  assign pixel_y     = r_pixel_y;
  assign v_count     = r_v_count;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifndef SYNTHESIS
  function automatic v_state_e phase_of(input logic [15:0] v);
    if (v < LP_V_FP_START)    return StVAct;
    else if (v < LP_VS_START) return StVFp;
    else if (v < LP_VB_START) return StVSync;
    else                      return StVBp;
  endfunction

  // The FSM is redundant with the counter; they must never disagree.
  state_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
    r_state == phase_of(r_v_count));
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed self-checking bench for vga_sync_gen (default 640x480 timing, active-low syncs).
module tb_vga_sync_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] h_count_i;
  logic        v_count_en_i;
  logic        hsync, vsync, video_on, line_start, frame_start;
  logic [9:0]  pixel_x, pixel_y;
  logic [15:0] v_count;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]  frame_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int v_exp;

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .h_count_i    (h_count_i),
    .v_count_en_i (v_count_en_i),
    .hsync        (hsync),
    .vsync        (vsync),
    .video_on     (video_on),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .v_count      (v_count),
    .line_start   (line_start),
`ifdef VGA_FRAME_CNT_EN
    .frame_start  (frame_start),
    .frame_cnt    (frame_cnt)
`else
    .frame_start  (frame_start)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic tick(input logic [15:0] h, input logic en);
    h_count_i    = h;
    v_count_en_i = en;
    @(posedge clk);
    #1;
  endtask

  int unsigned hv[11]  = '{0, 1, 639, 640, 655, 656, 751, 752, 799, 800, 65535};
  bit          hva[11] = '{1, 1, 1,   0,   0,   0,   0,   0,   0,   0,   0};
  bit          hhs[11] = '{1, 1, 1,   1,   1,   0,   0,   1,   1,   1,   1};

  initial begin
    // Reset held for three cycles.
    rst_n = 1'b0;
    tick(16'd100, 1'b0);
    tick(16'd100, 1'b0);
    tick(16'd100, 1'b0);
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_vsync", 32'(vsync), 1);
    chk("rst_video_on", 32'(video_on), 0);
    chk("rst_v_count", 32'(v_count), 0);
    chk("rst_line_start", 32'(line_start), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_pixel_x", 32'(pixel_x), 0);
    chk("rst_pixel_y", 32'(pixel_y), 0);

    rst_n = 1'b1;
    tick(16'd100, 1'b0);
    chk("l0_video_on", 32'(video_on), 1);
    chk("l0_pixel_x", 32'(pixel_x), 100);

    // First line pulse: new line visible immediately, column 0.
    tick(16'd0, 1'b1);
    chk("l1_v_count", 32'(v_count), 1);
    chk("l1_line_start", 32'(line_start), 1);
    chk("l1_pixel_x", 32'(pixel_x), 0);
    chk("l1_pixel_y", 32'(pixel_y), 1);
    chk("l1_video_on", 32'(video_on), 1);
    for (int i = 0; i < 9; i++) tick(16'd0, 1'b1);
    tick(16'd1, 1'b0);
    chk("l10_v_count", 32'(v_count), 10);
    chk("l10_line_start", 32'(line_start), 0);

    // Horizontal boundary vectors on line 10.
    for (int i = 0; i < 11; i++) begin
      tick(16'(hv[i]), 1'b0);
      chk($sformatf("h%0d_video_on", hv[i]), 32'(video_on), 32'(hva[i]));
      chk($sformatf("h%0d_hsync", hv[i]), 32'(hsync), 32'(hhs[i]));
      chk($sformatf("h%0d_pixel_x", hv[i]), 32'(pixel_x), hva[i] ? hv[i] : 0);
      chk($sformatf("h%0d_pixel_y", hv[i]), 32'(pixel_y), hva[i] ? 10 : 0);
      chk($sformatf("h%0d_vsync", hv[i]), 32'(vsync), 1);
    end

    // Walk through the rest of the frame and wrap to line 0.
    v_exp = 10;
    for (int i = 0; i < 515; i++) begin
      tick(16'd0, 1'b1);
      v_exp = (v_exp == 524) ? 0 : v_exp + 1;
      chk($sformatf("v%0d_v_count", v_exp), 32'(v_count), 32'(v_exp));
      chk($sformatf("v%0d_vsync", v_exp), 32'(vsync), (v_exp == 490 || v_exp == 491) ? 0 : 1);
      chk($sformatf("v%0d_video_on", v_exp), 32'(video_on), (v_exp < 480) ? 1 : 0);
      chk($sformatf("v%0d_frame_start", v_exp), 32'(frame_start), (v_exp == 0) ? 1 : 0);
    end
    chk("wrap_line_start", 32'(line_start), 1);
    tick(16'd5, 1'b0);
    chk("post_wrap_frame_start", 32'(frame_start), 0);
    chk("post_wrap_line_start", 32'(line_start), 0);
    chk("post_wrap_pixel_x", 32'(pixel_x), 5);
`ifdef VGA_FRAME_CNT_EN
    chk("frame_cnt_one", 32'(frame_cnt), 1);
`endif

    // Advance to line 300, then a one-cycle reset mid-frame.
    for (int i = 0; i < 300; i++) tick(16'd0, 1'b1);
    tick(16'd50, 1'b0);
    chk("l300_v_count", 32'(v_count), 300);
    chk("l300_pixel_y", 32'(pixel_y), 300);
    rst_n = 1'b0;
    tick(16'd200, 1'b0);
    rst_n = 1'b1;
    chk("mid_rst_v_count", 32'(v_count), 0);
    chk("mid_rst_video_on", 32'(video_on), 0);
    chk("mid_rst_hsync", 32'(hsync), 1);
    chk("mid_rst_pixel_x", 32'(pixel_x), 0);
    chk("mid_rst_pixel_y", 32'(pixel_y), 0);
`ifdef VGA_FRAME_CNT_EN
    chk("mid_rst_frame_cnt", 32'(frame_cnt), 0);
`endif
    tick(16'd201, 1'b0);
    chk("after_rst_pixel_x", 32'(pixel_x), 201);
    chk("after_rst_pixel_y", 32'(pixel_y), 0);
    tick(16'd0, 1'b1);
    chk("after_rst_v_count", 32'(v_count), 1);
    chk("after_rst_frame_start", 32'(frame_start), 0);
    chk("after_rst_line_start", 32'(line_start), 1);

    // Back-to-back pulses each count; a pulse mid-line is honoured too.
    tick(16'd0, 1'b1);
    tick(16'd0, 1'b1);
    chk("b2b_v_count", 32'(v_count), 3);
    tick(16'd700, 1'b1);
    chk("midline_v_count", 32'(v_count), 4);
    chk("midline_hsync", 32'(hsync), 0);
    chk("midline_video_on", 32'(video_on), 0);
    chk("midline_line_start", 32'(line_start), 1);
    tick(16'd700, 1'b0);
    chk("hold_v_count", 32'(v_count), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
